nco_sweep_ctrl: RTL and testbench

- Sequencer for the 1 MHz NCO datapath. It drives the NCO's phase-increment input and clock enable, so the NCO generates a stepped-frequency sweep of N points.
- Each point is held for D cycles.
- Pipeline priming and flushing: the controller runs the NCO pipeline for LAT cycles before the first point and after the last point, so every point produces valid output samples.
- Sits between the acquisition control logic (start/abort handshake) and the NCO instance.

---
 rtl/nco_sweep_ctrl.sv | 179 +++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the NCO.
// Primes the NCO pipeline, sweeps N points of D cycles each, then flushes it.
module nco_sweep_ctrl #(
  parameter int APR  = 32,
  parameter int CNTW = 16,
  parameter int LAT  = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [APR-1:0]  cfg_phi_start,
  input  logic [APR-1:0]  cfg_phi_step,
  input  logic [CNTW-1:0] cfg_nsteps,
  input  logic [CNTW-1:0] cfg_dwell,
  input  logic            nco_out_valid,
  output logic            nco_clken,
  output logic [APR-1:0]  phi_inc_o,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [CNTW-1:0] step_idx,
  output logic            err_valid
);

  localparam int LCW = (LAT < 2) ? 1 : $clog2(LAT);
  localparam logic [LCW-1:0] LAT_LAST = LCW'(LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SWEEP,
    FLUSH,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LCW-1:0]  latCnt_q, latCnt_d;
  logic [CNTW-1:0] dwellCnt_q, dwellCnt_d;
  logic [CNTW-1:0] stepIdx_q, stepIdx_d;
  logic [CNTW-1:0] stepLast_q, stepLast_d;
  logic [CNTW-1:0] dwellLast_q, dwellLast_d;
  logic [APR-1:0]  phiStep_q, phiStep_d;
  logic [APR-1:0]  phiInc_q, phiInc_d;
  logic            clken_q, clken_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic            err_q, err_d;

  always_comb begin
    state_d     = state_q;
    latCnt_d    = latCnt_q;
    dwellCnt_d  = dwellCnt_q;
    stepIdx_d   = stepIdx_q;
    stepLast_d  = stepLast_q;
    dwellLast_d = dwellLast_q;
    phiStep_d   = phiStep_q;
    phiInc_d    = phiInc_q;
    clken_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          // Store last-index forms (N-1, D-1) so the counters are only ever compared.
          stepLast_d  = (cfg_nsteps == '0) ? '0 : cfg_nsteps - CNTW'(1);
          dwellLast_d = (cfg_dwell == '0) ? '0 : cfg_dwell - CNTW'(1);
          phiStep_d   = cfg_phi_step;
          phiInc_d    = cfg_phi_start;
          stepIdx_d   = '0;
          latCnt_d    = '0;
          err_d       = 1'b0;
          clken_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = PRIME;
        end
      end
      PRIME: begin
        clken_d = 1'b1;
        busy_d  = 1'b1;
        if (latCnt_q == LAT_LAST) begin
          dwellCnt_d = '0;
          state_d    = SWEEP;
        end else begin
          latCnt_d = latCnt_q + LCW'(1);
        end
      end
      SWEEP: begin
        clken_d = 1'b1;
        busy_d  = 1'b1;
        if (!nco_out_valid) err_d = 1'b1;
        if (dwellCnt_q == dwellLast_q) begin
          dwellCnt_d = '0;
          if (stepIdx_q == stepLast_q) begin
            latCnt_d = '0;
            state_d  = FLUSH;
          end else begin
            stepIdx_d = stepIdx_q + CNTW'(1);
            phiInc_d  = phiInc_q + phiStep_q;
          end
        end else begin
          dwellCnt_d = dwellCnt_q + CNTW'(1);
        end
      end
      FLUSH: begin
        busy_d = 1'b1;
        if (latCnt_q == LAT_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          clken_d  = 1'b1;
          latCnt_d = latCnt_q + LCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition out of the active states; DONE finishes normally.
    if (abort && (state_q == PRIME || state_q == SWEEP || state_q == FLUSH)) begin
      state_d   = IDLE;
      stepIdx_d = stepIdx_q;
      phiInc_d  = phiInc_q;
      clken_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      latCnt_q    <= '0;
      dwellCnt_q  <= '0;
      stepIdx_q   <= '0;
      stepLast_q  <= '0;
      dwellLast_q <= '0;
      phiStep_q   <= '0;
      phiInc_q    <= '0;
      clken_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      latCnt_q    <= latCnt_d;
      dwellCnt_q  <= dwellCnt_d;
      stepIdx_q   <= stepIdx_d;
      stepLast_q  <= stepLast_d;
      dwellLast_q <= dwellLast_d;
      phiStep_q   <= phiStep_d;
      phiInc_q    <= phiInc_d;
      clken_q     <= clken_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
    end
  end

  assign nco_clken = clken_q;
  assign phi_inc_o = phiInc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign step_idx  = stepIdx_q;
  assign err_valid = err_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomized self-checking bench for nco_sweep_ctrl; each sweep's expected
// cycle-by-cycle output trace is built from the sweep rules before it is run.
module tb_nco_sweep_ctrl;

  localparam int APR  = 32;
  localparam int CNTW = 16;
  localparam int LAT  = 10;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            abort;
  logic [APR-1:0]  cfg_phi_start;
  logic [APR-1:0]  cfg_phi_step;
  logic [CNTW-1:0] cfg_nsteps;
  logic [CNTW-1:0] cfg_dwell;
  logic            nco_out_valid;
  logic            nco_clken;
  logic [APR-1:0]  phi_inc_o;
  logic            busy;
  logic            done;
  logic            aborted;
  logic [CNTW-1:0] step_idx;
  logic            err_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            clken;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [APR-1:0]  phi;
    logic [CNTW-1:0] idx;
  } exp_t;

  nco_sweep_ctrl #(.APR(APR), .CNTW(CNTW), .LAT(LAT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .cfg_phi_start (cfg_phi_start),
    .cfg_phi_step  (cfg_phi_step),
    .cfg_nsteps    (cfg_nsteps),
    .cfg_dwell     (cfg_dwell),
    .nco_out_valid (nco_out_valid),
    .nco_clken     (nco_clken),
    .phi_inc_o     (phi_inc_o),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .step_idx      (step_idx),
    .err_valid     (err_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".clken"}, 32'(nco_clken), 32'd0);
    checkOutput({tag, ".phi"}, phi_inc_o, 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".aborted"}, 32'(aborted), 32'd0);
    checkOutput({tag, ".idx"}, 32'(step_idx), 32'd0);
    checkOutput({tag, ".err"}, 32'(err_valid), 32'd0);
  endtask

  // abortAt / invalidAt are trace indices (trace entry i is cycle i+1 after the start edge); -1 disables.
  task automatic applyStimulus(input string name, input logic [APR-1:0] phiStart, input logic [APR-1:0] phiStep,
                               input logic [CNTW-1:0] n, input logic [CNTW-1:0] d,
                               input int abortAt, input int invalidAt, input bit disturb);
    exp_t q[$];
    exp_t e;
    int   nEff;
    int   dEff;
    logic errExp;

    nEff = (n == 0) ? 1 : int'(n);
    dEff = (d == 0) ? 1 : int'(d);
    e.clken = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.aborted = 1'b0;
    e.phi = phiStart; e.idx = '0;
    for (int i = 0; i < LAT; i++) q.push_back(e);
    for (int p = 0; p < nEff; p++) begin
      e.phi = phiStart + phiStep * 32'(p);
      e.idx = CNTW'(p);
      for (int k = 0; k < dEff; k++) q.push_back(e);
    end
    for (int i = 0; i < LAT; i++) q.push_back(e);
    e.clken = 1'b0; e.done = 1'b1;
    q.push_back(e);
    e.done = 1'b0; e.busy = 1'b0;
    q.push_back(e);
    if (abortAt >= 0) begin
      e = q[abortAt];
      while (q.size() > abortAt + 1) void'(q.pop_back());
      e.clken = 1'b0; e.busy = 1'b0; e.aborted = 1'b1;
      q.push_back(e);
      e.aborted = 1'b0;
      q.push_back(e);
    end

    @(negedge clk);
    cfg_phi_start = phiStart;
    cfg_phi_step  = phiStep;
    cfg_nsteps    = n;
    cfg_dwell     = d;
    start         = 1'b1;
    abort         = 1'b0;
    nco_out_valid = 1'b1;
    errExp        = 1'b0;

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.clken[%0d]", name, i + 1), 32'(nco_clken), 32'(q[i].clken));
      checkOutput($sformatf("%s.busy[%0d]", name, i + 1), 32'(busy), 32'(q[i].busy));
      checkOutput($sformatf("%s.done[%0d]", name, i + 1), 32'(done), 32'(q[i].done));
      checkOutput($sformatf("%s.aborted[%0d]", name, i + 1), 32'(aborted), 32'(q[i].aborted));
      checkOutput($sformatf("%s.phi[%0d]", name, i + 1), phi_inc_o, q[i].phi);
      checkOutput($sformatf("%s.idx[%0d]", name, i + 1), 32'(step_idx), 32'(q[i].idx));
      checkOutput($sformatf("%s.err[%0d]", name, i + 1), 32'(err_valid), 32'(errExp));
      start         = 1'b0;
      abort         = (i == abortAt);
      nco_out_valid = (i != invalidAt);
      if (i == invalidAt) errExp = 1'b1;
      if (disturb && q[i].busy) begin
        start         = 1'($urandom_range(0, 1));
        cfg_phi_start = $urandom();
        cfg_phi_step  = $urandom();
        cfg_nsteps    = CNTW'($urandom_range(0, 7));
        cfg_dwell     = CNTW'($urandom_range(0, 7));
      end
    end
    start         = 1'b0;
    abort         = 1'b0;
    nco_out_valid = 1'b1;
  endtask

  initial begin
    int total;
    int nR;
    int dR;
    int abortR;
    int invR;

    reset_n       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    cfg_phi_start = '0;
    cfg_phi_step  = '0;
    cfg_nsteps    = '0;
    cfg_dwell     = '0;
    nco_out_valid = 1'b1;
    #12;
    checkAllZero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus("nominal", 32'h0000_1000, 32'h0000_0100, 16'd3, 16'd2, -1, -1, 1'b0);
    applyStimulus("degenerate", 32'h1234_5678, 32'h0000_0100, 16'd0, 16'd0, -1, -1, 1'b0);
    applyStimulus("wrapUp", 32'hFFFF_FF80, 32'h0000_0100, 16'd2, 16'd1, -1, -1, 1'b0);
    applyStimulus("wrapDown", 32'h0000_0080, 32'hFFFF_FF00, 16'd2, 16'd1, -1, -1, 1'b0);
    applyStimulus("abortSweep", 32'h0000_2000, 32'h0000_0010, 16'd4, 16'd2, LAT + 2, -1, 1'b0);
    applyStimulus("disturb", 32'h0ABC_0000, 32'h0000_0400, 16'd3, 16'd3, -1, -1, 1'b1);
    applyStimulus("errValid", 32'h0000_3000, 32'h0000_0100, 16'd3, 16'd2, -1, LAT + 1, 1'b0);
    applyStimulus("errClear", 32'h0000_4000, 32'h0000_0100, 16'd1, 16'd2, -1, -1, 1'b0);

    // start and abort together while idle must not begin a sweep
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startAbort.busy", 32'(busy), 32'd0);
    checkOutput("startAbort.clken", 32'(nco_clken), 32'd0);
    @(negedge clk);
    checkOutput("startAbort.busy2", 32'(busy), 32'd0);

    for (int r = 0; r < 16; r++) begin
      nR     = $urandom_range(0, 5);
      dR     = $urandom_range(0, 4);
      total  = 2 * LAT + ((nR == 0) ? 1 : nR) * ((dR == 0) ? 1 : dR);
      abortR = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      invR   = ($urandom_range(0, 3) == 0) ? LAT + int'($urandom_range(0, total - 2 * LAT - 1)) : -1;
      if (abortR >= 0 && invR > abortR) invR = -1;
      applyStimulus($sformatf("rand%0d", r), $urandom(), $urandom(), CNTW'(nR), CNTW'(dR),
                    abortR, invR, 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a sweep, with err_valid set beforehand
    @(negedge clk);
    cfg_phi_start = 32'h5555_0000;
    cfg_phi_step  = 32'h0000_0100;
    cfg_nsteps    = 16'd6;
    cfg_dwell     = 16'd3;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    nco_out_valid = 1'b0;
    @(negedge clk);
    nco_out_valid = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("preReset.err", 32'(err_valid), 32'd1);
    checkOutput("preReset.busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("asyncReset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("postReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
